dense_layer_ctrl: RTL and testbench
===================================

# dense_layer_ctrl

Sequencer that evaluates a full fully-connected layer on one shared `dense` neuron unit, one output neuron at a time. It captures the layer input vector, fetches each neuron's weight row and bias from an external synchronous ROM, and pulses the neuron's `start`. It collects each result, applies optional ReLU, and streams results out over a valid/ready port. It sits between the conv/pool feature stage and the classifier output buffer.

## Interface
- `N`, 16: data width, signed fixed-point.
- `Q`, 8: fractional bits; informational, no arithmetic here depends on it.
- `NUM_INPUTS`, 4: elements per input vector and per weight row.
- `NUM_OUTPUTS`, 3: neurons in the layer (≥1).
- `RELU`, 1: 1 applies ReLU to each result; 0 passes it through unchanged.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to run the layer; sampled only in IDLE.
- `in_vec`  in  NUM_INPUTS*N  layer input; element k at bits [k*N +: N]; captured on accepted `start`.
- `busy`  out  1  high from accepted start until `done`.
- `done`  out  1  one-cycle pulse after the last result is accepted.
- `rom_rd_en`  out  1  ROM read strobe.
- `rom_addr`  out  clog2(NUM_OUTPUTS) (min 1)  neuron row index.
- `rom_rdata`  in  (NUM_INPUTS+1)*N  row data valid the cycle after `rom_rd_en`; weight k at [k*N +: N], bias at the top N bits.
- `nrn_start`  out  1  one-cycle start pulse to the neuron.
- `nrn_in_vec`  out  NUM_INPUTS*N  registered copy of `in_vec`.
- `nrn_w_vec`  out  NUM_INPUTS*N  registered weight row.
- `nrn_bias`  out  N  registered bias.
- `nrn_done`  in  1  neuron completion pulse.
- `nrn_out`  in  N  neuron result; valid while `nrn_done` is high.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts when high together with `out_valid`.
- `out_idx`  out  clog2(NUM_OUTPUTS) (min 1)  neuron index of `out_data`.
- `out_data`  out  N  signed result after optional ReLU.

## Operation
- States: IDLE, FETCH, LATCH, FIRE, WAIT, EMIT, FINISH.
- IDLE:
  - On `start`: capture `in_vec`, set row=0, set `busy`, go to FETCH.
- FETCH:
  - `rom_rd_en`=1, `rom_addr`=row; go to LATCH.
- LATCH:
  - Register `rom_rdata` into `nrn_w_vec`/`nrn_bias`; go to FIRE.
- FIRE:
  - `nrn_start`=1 for exactly this cycle; go to WAIT.
- WAIT:
  - On `nrn_done`: register `out_data` = (RELU and `nrn_out`<0) ? 0 : `nrn_out`, `out_idx`=row; go to EMIT.
- EMIT:
  - Hold `out_valid`, `out_data` and `out_idx` stable until `out_valid && out_ready`.
  - On handshake: if row==NUM_OUTPUTS-1 go to FINISH; else row+1 and go to FETCH.
- FINISH:
  - `done`=1, `busy`=0; go to IDLE.
- Operand stability:
  - `nrn_in_vec`, `nrn_w_vec` and `nrn_bias` are held constant from FIRE through WAIT, because the neuron reads elements during its run.
  - `nrn_in_vec` changes only on an accepted `start`.
- Ignored inputs:
  - `start` outside IDLE.
  - `nrn_done` outside WAIT.
  - `out_ready` outside EMIT.
- ReLU is a sign test only; there is no saturation or rescaling.

## Timing
- Reset values:
  - `busy`, `done`, `rom_rd_en`, `nrn_start`, `out_valid` = 0.
  - `rom_addr`, `out_idx`, `out_data`, `nrn_in_vec`, `nrn_w_vec`, `nrn_bias` = 0.
  - State = IDLE.
- Reset assertion mid-layer aborts immediately. No `done`, no further `out_valid`, and no partial state survives.
- All outputs are registered, or decoded from state only. No combinational path from an input to an output.
- Define L = cycles from `nrn_start` high to `nrn_done` high; L = NUM_INPUTS+3 with the team's `dense`.
- Per-neuron cost with `out_ready` tied high is L+4 cycles, from FETCH to the next FETCH.
- `busy` rises the cycle after `start` is sampled.
- `done` pulses the cycle after the final handshake. `start` may be accepted again on the cycle after `done`.
- Back-pressure: each cycle of `out_ready` low in EMIT adds one cycle. The neuron is idle meanwhile; no prefetch.

## Test plan
- Single layer: `in_vec`={0x0100,0x0200,0xFF00,0x0080}; row0 all weights 0x0100, bias 0; row1 all 0xFF00, bias 0; row2 all 0, bias 0x0040; RELU=1; `out_ready`=1.
  - Outputs (idx,data) = (0,0x0280), (1,0x0000), (2,0x0040).
  - `done` once, L+4 cycles after the last handshake's FETCH start; `busy` low after.
- Same as above with RELU=0 -> idx1 data = 0xFD80.
- `out_ready` low for 5 cycles on idx1:
  - `out_valid`/`out_data`/`out_idx` stable throughout.
  - No ROM read or `nrn_start` during the stall.
  - Total latency +5.
- `start` pulsed while busy, and a spurious `nrn_done` injected in EMIT:
  - Both ignored; exactly NUM_OUTPUTS results; one `done`.
- `reset_n` low during WAIT of row1:
  - All outputs at reset values during reset and after release.
  - A fresh `start` runs the full layer from idx0 correctly.
- Back-to-back layers: `start` the cycle after `done` with a new `in_vec` -> second layer results use only the new vector.

Source files
------------

// File: rtl/dense_layer_ctrl_if.sv
// Bundle of the sequencer's start/status, weight ROM, neuron and result-stream signals.
// out_valid/out_ready: a result transfers on a rising clk edge where both are high; data and idx hold while valid waits.
interface dense_layer_ctrl_if #(
    parameter int N           = 16,
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_OUTPUTS = 3
) ();
    localparam int AW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

    logic                        start;
    logic [NUM_INPUTS*N-1:0]     in_vec;
    logic                        busy;
    logic                        done;
    logic                        rom_rd_en;
    logic [AW-1:0]               rom_addr;
    logic [(NUM_INPUTS+1)*N-1:0] rom_rdata;
    logic                        nrn_start;
    logic [NUM_INPUTS*N-1:0]     nrn_in_vec;
    logic [NUM_INPUTS*N-1:0]     nrn_w_vec;
    logic [N-1:0]                nrn_bias;
    logic                        nrn_done;
    logic [N-1:0]                nrn_out;
    logic                        out_valid;
    logic                        out_ready;
    logic [AW-1:0]               out_idx;
    logic [N-1:0]                out_data;

    modport master (
        input  start, in_vec, rom_rdata, nrn_done, nrn_out, out_ready,
        output busy, done, rom_rd_en, rom_addr, nrn_start, nrn_in_vec,
               nrn_w_vec, nrn_bias, out_valid, out_idx, out_data
    );

    modport slave (
        output start, in_vec, rom_rdata, nrn_done, nrn_out, out_ready,
        input  busy, done, rom_rd_en, rom_addr, nrn_start, nrn_in_vec,
               nrn_w_vec, nrn_bias, out_valid, out_idx, out_data
    );
endinterface

// File: rtl/dense_layer_ctrl.sv
// Runs one fully-connected layer on a single shared neuron: fetch row, fire, collect,
// optional ReLU, stream out. One neuron in flight at a time, no prefetch.
module dense_layer_ctrl #(
    parameter int N           = 16,
    parameter int Q           = 8,
    parameter int NUM_INPUTS  = 4,
    parameter int NUM_OUTPUTS = 3,
    parameter int RELU        = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dense_layer_ctrl_if.master    bus,
    output logic [2:0]            o_dbg_state
);
    localparam int              AW       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int              VW       = NUM_INPUTS * N;
    localparam logic [AW-1:0]   LAST_ROW = AW'(NUM_OUTPUTS - 1);

    // Q only describes the number format; reject formats with no integer bit.
    if (Q < 0 || Q >= N) begin : g_q_range
        $error("dense_layer_ctrl: Q must lie in [0, N-1]");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LATCH  = 3'd2,
        S_FIRE   = 3'd3,
        S_WAIT   = 3'd4,
        S_EMIT   = 3'd5,
        S_FINISH = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_row;
    logic [VW-1:0]   r_in_vec;
    logic [VW-1:0]   r_w_vec;
    logic [N-1:0]    r_bias;
    logic [AW-1:0]   r_out_idx;
    logic [N-1:0]    r_out_data;
    logic            w_handshake;
    logic            w_last_row;
    logic [N-1:0]    w_relu_out;

    assign w_handshake = (r_state == S_EMIT) && bus.out_ready;
    assign w_last_row  = (r_row == LAST_ROW);
    assign w_relu_out  = ((RELU != 0) && bus.nrn_out[N-1]) ? '0 : bus.nrn_out;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_FETCH;
            S_FETCH:  w_next = S_LATCH;
            S_LATCH:  w_next = S_FIRE;
            S_FIRE:   w_next = S_WAIT;
            S_WAIT:   if (bus.nrn_done) w_next = S_EMIT;
            S_EMIT:   if (w_handshake) w_next = w_last_row ? S_FINISH : S_FETCH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Operands only move in IDLE and LATCH, so they are frozen across FIRE and WAIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row      <= '0;
            r_in_vec   <= '0;
            r_w_vec    <= '0;
            r_bias     <= '0;
            r_out_idx  <= '0;
            r_out_data <= '0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_in_vec <= bus.in_vec;
                r_row    <= '0;
            end
            if (r_state == S_LATCH) begin
                r_w_vec <= bus.rom_rdata[VW-1:0];
                r_bias  <= bus.rom_rdata[VW +: N];
            end
            if (r_state == S_WAIT && bus.nrn_done) begin
                r_out_data <= w_relu_out;
                r_out_idx  <= r_row;
            end
            if (w_handshake && !w_last_row) begin
                r_row <= r_row + AW'(1);
            end
        end
    end

    assign bus.busy       = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign bus.done       = (r_state == S_FINISH);
    assign bus.rom_rd_en  = (r_state == S_FETCH);
    assign bus.rom_addr   = r_row;
    assign bus.nrn_start  = (r_state == S_FIRE);
    assign bus.nrn_in_vec = r_in_vec;
    assign bus.nrn_w_vec  = r_w_vec;
    assign bus.nrn_bias   = r_bias;
    assign bus.out_valid  = (r_state == S_EMIT);
    assign bus.out_idx    = r_out_idx;
    assign bus.out_data   = r_out_data;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_dense_layer_ctrl.sv
// Directed bench: a ReLU and a pass-through instance run the same layers side by side
// against a ROM model and a fixed-latency neuron model.
module tb_dense_layer_ctrl;
  localparam int N    = 16;
  localparam int Q    = 8;
  localparam int NI   = 4;
  localparam int NO   = 3;
  localparam int L    = NI + 3;
  localparam int AW   = 2;
  localparam int MAXC = 300;

  localparam logic [NI*N-1:0] VEC_A = {16'h0080, 16'hFF00, 16'h0200, 16'h0100};
  localparam logic [NI*N-1:0] VEC_B = {16'h0100, 16'h0100, 16'h0100, 16'h0100};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             start;
  logic             out_ready;
  logic             spur;
  logic [NI*N-1:0]  in_vec;
  logic [(NI+1)*N-1:0] rom_mem [NO];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] neuron_model(input logic [NI*N-1:0] x,
                                                input logic [NI*N-1:0] w,
                                                input logic [N-1:0] b);
    logic signed [2*N+3:0] acc;
    acc = '0;
    for (int k = 0; k < NI; k++)
      acc = acc + $signed(x[k*N +: N]) * $signed(w[k*N +: N]);
    acc = acc >>> Q;
    return acc[N-1:0] + b;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dense_layer_ctrl_if #(.N(N), .NUM_INPUTS(NI), .NUM_OUTPUTS(NO)) bus ();
    logic [2:0]      dbg_state;
    logic            m_done = 1'b0;
    logic [N-1:0]    m_out  = '0;
    int              m_cnt  = 0;
    logic [AW+N-1:0] exp_q[$];
    int              n_res  = 0;
    int              n_done = 0;

    assign bus.start     = start;
    assign bus.in_vec    = in_vec;
    assign bus.out_ready = out_ready;
    assign bus.nrn_done  = m_done | spur;
    assign bus.nrn_out   = spur ? 16'h7777 : m_out;

    dense_layer_ctrl #(.N(N), .Q(Q), .NUM_INPUTS(NI), .NUM_OUTPUTS(NO),
                       .RELU(g == 0 ? 1 : 0)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus),
      .o_dbg_state(dbg_state)
    );

    always @(posedge clk)
      if (bus.rom_rd_en) bus.rom_rdata <= rom_mem[bus.rom_addr];

    // Neuron: done arrives L cycles after start, computed from the operands seen at that time.
    always @(posedge clk) begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_out  <= neuron_model(bus.nrn_in_vec, bus.nrn_w_vec, bus.nrn_bias);
        end
      end else if (bus.nrn_start) begin
        m_cnt <= L - 1;
      end
    end

    always @(negedge clk) begin
      if (reset_n) begin
        if (bus.done) n_done <= n_done + 1;
        if (bus.out_valid && bus.out_ready) begin
          n_res <= n_res + 1;
          check_eq(g == 0 ? "res_avail_relu" : "res_avail_lin", exp_q.size() > 0, 1);
          if (exp_q.size() > 0)
            check_eq(g == 0 ? "result_relu" : "result_lin",
                     {bus.out_idx, bus.out_data}, exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check_eq({tag, "_flags"}, {g_dut[0].bus.busy, g_dut[0].bus.done, g_dut[0].bus.rom_rd_en,
                               g_dut[0].bus.nrn_start, g_dut[0].bus.out_valid}, 0);
    check_eq({tag, "_outregs"}, {g_dut[0].bus.rom_addr, g_dut[0].bus.out_idx,
                                 g_dut[0].bus.out_data}, 0);
    check_eq({tag, "_in_vec"}, g_dut[0].bus.nrn_in_vec, 0);
    check_eq({tag, "_w_vec"}, g_dut[0].bus.nrn_w_vec, 0);
    check_eq({tag, "_bias"}, {g_dut[0].bus.nrn_bias, g_dut[1].bus.out_valid,
                              g_dut[1].bus.busy}, 0);
    check_eq({tag, "_state"}, g_dut[0].dbg_state, 0);
  endtask

  task automatic push_layer(input logic [N-1:0] d0, input logic [N-1:0] d1_relu,
                            input logic [N-1:0] d1_lin, input logic [N-1:0] d2);
    g_dut[0].exp_q.push_back({2'd0, d0});
    g_dut[0].exp_q.push_back({2'd1, d1_relu});
    g_dut[0].exp_q.push_back({2'd2, d2});
    g_dut[1].exp_q.push_back({2'd0, d0});
    g_dut[1].exp_q.push_back({2'd1, d1_lin});
    g_dut[1].exp_q.push_back({2'd2, d2});
  endtask

  // mode 0 plain, 1 stall idx1 for 5 cycles, 2 stray start/nrn_done, 3 reset in WAIT of row1
  task automatic run_layer(input string tag, input logic [NI*N-1:0] vec,
                           input int exp_cyc, input int mode);
    int   cyc, left, bad, base_d0, base_d1, base_r0, base_r1;
    bit   seen, stalled, spurred, aborted;
    logic [AW+N-1:0] hold;
    base_d0 = g_dut[0].n_done; base_d1 = g_dut[1].n_done;
    base_r0 = g_dut[0].n_res;  base_r1 = g_dut[1].n_res;
    seen = 0; stalled = 0; spurred = 0; aborted = 0; left = 0; bad = 0; hold = '0;
    in_vec = vec;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    check_eq({tag, "_busy_rise"}, {g_dut[0].bus.busy, g_dut[1].bus.busy}, 2'b11);
    check_eq({tag, "_in_capture"}, g_dut[0].bus.nrn_in_vec, vec);
    while (!seen && !aborted && cyc < MAXC) begin
      @(posedge clk); #1;
      cyc++;
      spur = 1'b0;
      if (mode == 1) begin
        if (!stalled && g_dut[0].bus.out_valid && g_dut[0].bus.out_idx == 2'd1) begin
          stalled = 1; left = 6; hold = {g_dut[0].bus.out_idx, g_dut[0].bus.out_data};
        end
        if (left > 0) begin
          if (!g_dut[0].bus.out_valid || {g_dut[0].bus.out_idx, g_dut[0].bus.out_data} !== hold)
            bad++;
          if (g_dut[0].bus.rom_rd_en || g_dut[0].bus.nrn_start) bad++;
          left--;
          out_ready = (left == 0);
        end
      end
      if (mode == 2) begin
        if (cyc == 5) begin start = 1'b1; in_vec = ~vec; end
        if (cyc == 6) start = 1'b0;
        if (!spurred && g_dut[0].bus.out_valid) begin spur = 1'b1; spurred = 1; end
      end
      if (mode == 3 && cyc == 16) begin
        check_eq({tag, "_in_wait_row1"}, {g_dut[0].dbg_state, g_dut[0].bus.rom_addr}, {3'd4, 2'd1});
        reset_n = 1'b0;
        aborted = 1;
      end
      if (g_dut[0].bus.done) seen = 1;
    end
    if (mode == 1) begin
      check_eq({tag, "_stall_seen"}, stalled, 1);
      check_eq({tag, "_stall_stable"}, bad, 0);
    end
    if (mode != 3) begin
      check_eq({tag, "_done_seen"}, seen, 1);
      check_eq({tag, "_latency"}, cyc, exp_cyc);
      check_eq({tag, "_done_both"}, g_dut[1].bus.done, 1);
      @(posedge clk); #1;
      check_eq({tag, "_idle_after"}, {g_dut[0].bus.busy, g_dut[0].bus.done}, 0);
      check_eq({tag, "_done_count"}, {16'(g_dut[0].n_done - base_d0), 16'(g_dut[1].n_done - base_d1)},
               {16'd1, 16'd1});
      check_eq({tag, "_res_count"}, {16'(g_dut[0].n_res - base_r0), 16'(g_dut[1].n_res - base_r1)},
               {16'd3, 16'd3});
      check_eq({tag, "_q_drained"}, g_dut[0].exp_q.size() + g_dut[1].exp_q.size(), 0);
    end else begin
      check_eq({tag, "_no_done"}, g_dut[0].n_done - base_d0, 0);
      check_eq({tag, "_partial"}, g_dut[0].n_res - base_r0, 1);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    spur      = 1'b0;
    in_vec    = VEC_A;
    rom_mem[0] = {16'h0000, {4{16'h0100}}};
    rom_mem[1] = {16'h0000, {4{16'hFF00}}};
    rom_mem[2] = {16'h0040, {4{16'h0000}}};
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_reset("por_release");

    push_layer(16'h0280, 16'h0000, 16'hFD80, 16'h0040);
    run_layer("layer", VEC_A, 3 * (L + 4), 0);

    push_layer(16'h0280, 16'h0000, 16'hFD80, 16'h0040);
    run_layer("stall", VEC_A, 3 * (L + 4) + 5, 1);

    push_layer(16'h0280, 16'h0000, 16'hFD80, 16'h0040);
    run_layer("stray", VEC_A, 3 * (L + 4), 2);

    push_layer(16'h0280, 16'h0000, 16'hFD80, 16'h0040);
    run_layer("abort", VEC_A, 0, 3);
    #1;
    check_reset("abort_hold");
    g_dut[0].exp_q.delete();
    g_dut[1].exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_reset("abort_release");
    repeat (12) @(posedge clk);
    #1;
    check_eq("abort_quiet", {g_dut[0].bus.out_valid, g_dut[0].bus.busy, g_dut[0].bus.done}, 0);

    push_layer(16'h0280, 16'h0000, 16'hFD80, 16'h0040);
    run_layer("fresh", VEC_A, 3 * (L + 4), 0);

    push_layer(16'h0400, 16'h0000, 16'hFC00, 16'h0040);
    run_layer("b2b", VEC_B, 3 * (L + 4), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
